// File: rtl/sif_mc.sv
// Multi-channel storage interface: NCH read/write X channels and one write-only
// W channel share one register array, with W-first / round-robin X arbitration.
module sif_mc #(
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int DEPTH  = 256,
    parameter int NCH    = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    xa_wr_s,
    input  logic [NCH-1:0]    xa_rd_s,
    input  logic [NCH*AW-1:0] xa_addr,
    input  logic [NCH*DW-1:0] xa_data_wr,
    output logic [NCH-1:0]    xa_gnt,
    output logic [NCH*DW-1:0] xa_data_rd,
    output logic [NCH-1:0]    xa_rd_vld,
    output logic [NCH-1:0]    xa_err,
    input  logic              wa_wr_s,
    input  logic [AW-1:0]     wa_addr,
    input  logic [DW-1:0]     wa_data_wr,
    output logic              wa_gnt,
    output logic              wa_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0]     mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [NCH-1:0]    xreq;
    logic              xvalid;
    logic [PW-1:0]     xsel;
    int                idx;
    logic [NCH-1:0]    gnt;
    logic [AW-1:0]     xaddr;
    logic [DW-1:0]     xwdata;
    logic              xwr;
    logic              xrd;
    logic              xinr;
    logic              winr;
    logic [DW-1:0]     xrdata;

    logic [RD_LAT-1:0] pv;
    logic [PW-1:0]     pch [RD_LAT];
    logic [DW-1:0]     pd  [RD_LAT];
    logic [NCH*DW-1:0] hold;
    logic [NCH*DW-1:0] rdout;
    logic [NCH-1:0]    vld;
    logic [NCH-1:0]    xerr;
    logic              werr;

    // Round-robin search from the pointer; W or reset suppresses every X grant.
    always_comb begin
        xreq   = xa_wr_s | xa_rd_s;
        xvalid = 1'b0;
        xsel   = '0;
        idx    = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!xvalid && xreq[idx]) begin
                xvalid = 1'b1;
                xsel   = PW'(idx);
            end
        end
        if (wa_wr_s || rst) xvalid = 1'b0;
    end

    always_comb begin
        gnt = '0;
        if (xvalid) gnt[xsel] = 1'b1;
    end

    assign wa_gnt = wa_wr_s & ~rst;
    assign xa_gnt = gnt;

    assign xaddr  = xa_addr[int'(xsel)*AW +: AW];
    assign xwdata = xa_data_wr[int'(xsel)*DW +: DW];
    assign xwr    = xa_wr_s[xsel];
    assign xrd    = xa_rd_s[xsel];
    // Upper address bits take part in the compare, so nothing aliases into range.
    assign xinr   = ({1'b0, xaddr} < DEPTH_W);
    assign winr   = ({1'b0, wa_addr} < DEPTH_W);
    assign xrdata = xinr ? mem[xaddr[IW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else if (wa_gnt && winr) begin
            mem[wa_addr[IW-1:0]] <= wa_data_wr;
        end else if (xvalid && xwr && xinr) begin
            mem[xaddr[IW-1:0]] <= xwdata;
        end
    end

    // Read pipeline stage 0 captures the array at the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            pv   <= '0;
            xerr <= '0;
            werr <= 1'b0;
            hold <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pch[k] <= '0;
                pd[k]  <= '0;
            end
        end else begin
            werr <= wa_gnt & ~winr;
            xerr <= '0;
            if (xvalid) xerr[xsel] <= (xwr & xrd) | ~xinr;
            pv[0]  <= xvalid & xrd & ~xwr;
            pch[0] <= xsel;
            pd[0]  <= xrdata;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k]  <= pv[k-1];
                pch[k] <= pch[k-1];
                pd[k]  <= pd[k-1];
            end
            hold <= rdout;
            if (xvalid) begin
                if (xsel == PW'(NCH-1)) ptr <= '0;
                else                    ptr <= xsel + 1'b1;
            end
        end
    end

    always_comb begin
        rdout = hold;
        vld   = '0;
        if (pv[RD_LAT-1]) begin
            vld[pch[RD_LAT-1]] = 1'b1;
            rdout[int'(pch[RD_LAT-1])*DW +: DW] = pd[RD_LAT-1];
        end
    end

    assign xa_data_rd = rdout;
    assign xa_rd_vld  = vld;
    assign xa_err     = xerr;
    assign wa_err     = werr;

endmodule

// File: tb/tb_sif_mc.sv
// Randomized bench for sif_mc against a transaction-level model of the shared
// array, arbitration order and read return timing.
module tb_sif_mc;

    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int DEPTH  = 256;
    localparam int NCH    = 2;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    xa_wr_s;
    logic [NCH-1:0]    xa_rd_s;
    logic [NCH*AW-1:0] xa_addr;
    logic [NCH*DW-1:0] xa_data_wr;
    logic [NCH-1:0]    xa_gnt;
    logic [NCH*DW-1:0] xa_data_rd;
    logic [NCH-1:0]    xa_rd_vld;
    logic [NCH-1:0]    xa_err;
    logic              wa_wr_s;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data_wr;
    logic              wa_gnt;
    logic              wa_err;

    sif_mc #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NCH(NCH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
        .xa_data_wr(xa_data_wr), .xa_gnt(xa_gnt), .xa_data_rd(xa_data_rd),
        .xa_rd_vld(xa_rd_vld), .xa_err(xa_err),
        .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
        .wa_gnt(wa_gnt), .wa_err(wa_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
        int due;
    } rd_t;

    int  nTests;
    int  nFail;
    int  mem [DEPTH];
    int  ptr;
    int  cyc;
    rd_t pend [$];
    int  expData [NCH];
    bit  expVld [NCH];
    bit  expErr [NCH];
    bit  expWErr;
    bit  gW;
    int  gX;
    int  lastGnt;

    bit  pWr [NCH];
    bit  pRd [NCH];
    int  pAddr [NCH];
    int  pData [NCH];
    bit  wReq;
    int  wAddr;
    int  wData;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit inRange(input int a);
        return (a >= 0) && (a < DEPTH);
    endfunction

    function automatic int pickAddr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return r;
        if (r == 16) return 255;
        if (r == 17) return 256;
        if (r == 18) return 16'hFFFF;
        return 16'h10F;
    endfunction

    task automatic driveInputs();
        for (int c = 0; c < NCH; c++) begin
            xa_wr_s[c]             = pWr[c];
            xa_rd_s[c]             = pRd[c];
            xa_addr[c*AW +: AW]    = AW'(pAddr[c]);
            xa_data_wr[c*DW +: DW] = DW'(pData[c]);
        end
        wa_wr_s    = wReq;
        wa_addr    = AW'(wAddr);
        wa_data_wr = DW'(wData);
    endtask

    task automatic clearRequests();
        for (int c = 0; c < NCH; c++) begin
            pWr[c]   = 1'b0;
            pRd[c]   = 1'b0;
            pAddr[c] = 0;
            pData[c] = 0;
        end
        wReq  = 1'b0;
        wAddr = 0;
        wData = 0;
    endtask

    task automatic modelReset();
        for (int j = 0; j < DEPTH; j++) mem[j] = 0;
        ptr = 0;
        pend.delete();
        for (int c = 0; c < NCH; c++) begin
            expData[c] = 0;
            expVld[c]  = 1'b0;
            expErr[c]  = 1'b0;
        end
        expWErr = 1'b0;
    endtask

    // Reset is raised mid-cycle, so it also aborts anything in flight.
    task automatic doReset();
        rst = 1'b1;
        clearRequests();
        driveInputs();
        #2;
        checkOutput("reset_xa_gnt", 32'(xa_gnt), 0);
        checkOutput("reset_wa_gnt", 32'(wa_gnt), 0);
        checkOutput("reset_rd_vld", 32'(xa_rd_vld), 0);
        checkOutput("reset_xa_err", 32'(xa_err), 0);
        checkOutput("reset_wa_err", 32'(wa_err), 0);
        checkOutput("reset_data", 32'(xa_data_rd), 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus();
        int op;
        for (int c = 0; c < NCH; c++) begin
            if (!pWr[c] && !pRd[c] && $urandom_range(0, 99) < 40) begin
                op       = $urandom_range(0, 9);
                pWr[c]   = (op <= 3) || (op == 9);
                pRd[c]   = (op >= 4);
                pAddr[c] = pickAddr();
                pData[c] = $urandom_range(0, 65535);
            end
        end
        wReq  = ($urandom_range(0, 99) < 20);
        wAddr = pickAddr();
        wData = $urandom_range(0, 65535);
    endtask

    task automatic modelEdge();
        int c;
        int rv;
        cyc++;
        for (int k = 0; k < NCH; k++) begin
            expErr[k] = 1'b0;
            expVld[k] = 1'b0;
        end
        expWErr = 1'b0;
        if (gW) begin
            if (inRange(wAddr)) mem[wAddr] = wData;
            else expWErr = 1'b1;
        end else if (gX >= 0) begin
            c = gX;
            if (!inRange(pAddr[c])) expErr[c] = 1'b1;
            if (pWr[c]) begin
                if (inRange(pAddr[c])) mem[pAddr[c]] = pData[c];
                if (pRd[c]) expErr[c] = 1'b1;
            end else begin
                rv = inRange(pAddr[c]) ? mem[pAddr[c]] : 0;
                pend.push_back('{ch: c, data: rv, due: cyc + RD_LAT - 1});
            end
            ptr = (c + 1) % NCH;
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
            expVld[pend[0].ch]  = 1'b1;
            expData[pend[0].ch] = pend[0].data;
            void'(pend.pop_front());
        end
    endtask

    task automatic stepCycle();
        logic [31:0] ev;
        logic [31:0] ee;
        driveInputs();
        gW = wReq;
        gX = -1;
        if (!gW) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (ptr + k) % NCH;
                if (gX < 0 && (pWr[c] || pRd[c])) gX = c;
            end
        end
        @(negedge clk);
        checkOutput("wa_gnt", 32'(wa_gnt), gW ? 1 : 0);
        checkOutput("xa_gnt", 32'(xa_gnt), (gX >= 0) ? (32'd1 << gX) : 32'd0);
        lastGnt = int'(xa_gnt);
        ev = '0;
        ee = '0;
        for (int c = 0; c < NCH; c++) begin
            ev[c] = expVld[c];
            ee[c] = expErr[c];
            checkOutput("xa_data_rd", 32'(xa_data_rd[c*DW +: DW]), expData[c]);
        end
        checkOutput("xa_rd_vld", 32'(xa_rd_vld), ev);
        checkOutput("xa_err", 32'(xa_err), ee);
        checkOutput("wa_err", 32'(wa_err), expWErr);
        @(posedge clk);
        modelEdge();
        #1;
        if (gX >= 0) begin
            pWr[gX] = 1'b0;
            pRd[gX] = 1'b0;
        end
        wReq = 1'b0;
    endtask

    function automatic bit anyPending();
        bit p;
        p = wReq;
        for (int c = 0; c < NCH; c++) p = p | pWr[c] | pRd[c];
        return p;
    endfunction

    task automatic drain();
        for (int n = 0; n < 30 && anyPending(); n++) stepCycle();
        for (int n = 0; n < RD_LAT + 2; n++) stepCycle();
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        cyc    = 0;
        rst    = 1'b1;
        clearRequests();
        driveInputs();
        modelReset();
        #1;
        doReset();

        // Read of a cleared word after reset.
        pRd[0] = 1'b1; pAddr[0] = 16'h0005;
        drain();

        // W write racing two X reads of the same word.
        doReset();
        wReq = 1'b1; wAddr = 16'h00A5; wData = 16'hBEEF;
        pRd[0] = 1'b1; pAddr[0] = 16'h00A5;
        pRd[1] = 1'b1; pAddr[1] = 16'h00A5;
        drain();
        checkOutput("t2_x0_data", 32'(xa_data_rd[0 +: DW]), 32'hBEEF);
        checkOutput("t2_x1_data", 32'(xa_data_rd[DW +: DW]), 32'hBEEF);

        // Continuous requests on both channels alternate.
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pRd[c]) begin
                    pRd[c] = 1'b1;
                    pAddr[c] = 16'h00A5;
                end
            end
            stepCycle();
            checkOutput("t3_alt", lastGnt, (k % 2 == 1) ? 2 : 1);
        end
        drain();

        // Out-of-range write then read on X1.
        pWr[1] = 1'b1; pAddr[1] = 16'h0100; pData[1] = 16'hDEAD;
        drain();
        pRd[1] = 1'b1; pAddr[1] = 16'h0100;
        drain();
        checkOutput("t4_x1_data", 32'(xa_data_rd[DW +: DW]), 0);

        // Simultaneous write and read: write wins.
        pWr[0] = 1'b1; pRd[0] = 1'b1; pAddr[0] = 16'h0010; pData[0] = 16'h1234;
        drain();
        pRd[0] = 1'b1; pAddr[0] = 16'h0010;
        drain();
        checkOutput("t5_x0_data", 32'(xa_data_rd[0 +: DW]), 32'h1234);

        // Reset lands while a read is in flight.
        wReq = 1'b1; wAddr = 16'h0020; wData = 16'h5555;
        stepCycle();
        pRd[0] = 1'b1; pAddr[0] = 16'h0020;
        stepCycle();
        doReset();
        pRd[0] = 1'b1; pAddr[0] = 16'h0020;
        drain();
        checkOutput("t6_x0_data", 32'(xa_data_rd[0 +: DW]), 0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            stepCycle();
            if (n == 200) doReset();
        end
        clearRequests();
        drain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
